// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with 8-entry TX and RX byte FIFOs.
// DATA sits at offset 0x0 and STATUS at 0x4; a STATUS read clears the sticky error flags.
module uart_mmio #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 3
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        en,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [7:0]  data_in,
    output logic [31:0] data_out,
    input  logic        RX,
    output logic        TX
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CW    = $clog2(DIV + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0]      CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0]      CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [FIFO_AW:0]   PTR_ONE  = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} line_state_t;

    logic [7:0]       tx_mem [DEPTH];
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             rd_en, stat_rd, tx_wr, tx_push, tx_pop, rx_push, rx_pop;
    logic             tx_ovf, rx_ovf, frame_err, rx_ovf_set, frame_set, tx_busy;
    line_state_t      tx_state, tx_next, rx_state, rx_next;
    logic [CW-1:0]    tx_cnt, rx_cnt;
    logic [2:0]       tx_idx, rx_idx;
    logic [7:0]       tx_sh, rx_sh;
    logic [1:0]       rx_sync;
    logic             rx_s, rx_prev, tx_tick, rx_tick;
    logic [31:0]      status, rdata;

    // Equal low bits distinguish full from empty by the wrap bit.
    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[FIFO_AW] != tx_rptr[FIFO_AW]) &&
                      (tx_wptr[FIFO_AW-1:0] == tx_rptr[FIFO_AW-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[FIFO_AW] != rx_rptr[FIFO_AW]) &&
                      (rx_wptr[FIFO_AW-1:0] == rx_rptr[FIFO_AW-1:0]);

    assign rd_en   = en & ~wr;
    assign stat_rd = rd_en & (addr == 4'h4);
    assign tx_wr   = en & wr & (addr == 4'h0);
    assign tx_push = tx_wr & ~tx_full;
    assign rx_pop  = rd_en & (addr == 4'h0) & ~rx_empty;
    assign rx_s    = rx_sync[1];
    assign tx_tick = (tx_cnt == '0);
    assign rx_tick = (rx_cnt == '0);
    assign tx_busy = (tx_state != IDLE) | ~tx_empty;
    assign status  = {25'd0, tx_busy, tx_ovf, frame_err, rx_ovf, ~rx_empty, tx_empty, tx_full};

    // Read data mux for the registered bus port.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            4'h0: begin
                if (!rx_empty) rdata = {24'd0, rx_mem[rx_rptr[FIFO_AW-1:0]]};
                else           rdata = 32'd0;
            end
            4'h4:    rdata = status;
            default: rdata = 32'd0;
        endcase
    end

    // Bus read register, sticky flags and FIFO pointers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            data_out  <= 32'd0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
            tx_wptr   <= '0;
            tx_rptr   <= '0;
            rx_wptr   <= '0;
            rx_rptr   <= '0;
        end else begin
            if (rd_en) data_out <= rdata;
            tx_ovf    <= (tx_wr & tx_full) | (tx_ovf & ~stat_rd);
            rx_ovf    <= rx_ovf_set | (rx_ovf & ~stat_rd);
            frame_err <= frame_set | (frame_err & ~stat_rd);
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
        end
    end

    // FIFO storage needs no reset; pointers define validity.
    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wptr[FIFO_AW-1:0]] <= data_in;
        if (rx_push) rx_mem[rx_wptr[FIFO_AW-1:0]] <= rx_sh;
    end

    // TX next-state: leaving IDLE pops the head byte.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = START;
                end else begin
                    tx_next = IDLE;
                end
            end
            START:   tx_next = tx_tick ? DATA : START;
            DATA:    tx_next = (tx_tick && tx_idx == 3'd7) ? STOP : DATA;
            STOP:    tx_next = tx_tick ? IDLE : STOP;
            default: tx_next = IDLE;
        endcase
    end

    // TX state, bit timer, shifter and registered line driver.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= CNT_BIT;
            tx_idx   <= 3'd0;
            tx_sh    <= 8'd0;
            TX       <= 1'b1;
        end else begin
            tx_state <= tx_next;
            if (tx_state == IDLE || tx_tick) tx_cnt <= CNT_BIT;
            else                             tx_cnt <= tx_cnt - CNT_ONE;
            if (tx_pop) begin
                tx_sh  <= tx_mem[tx_rptr[FIFO_AW-1:0]];
                tx_idx <= 3'd0;
            end else if (tx_state == DATA && tx_tick) begin
                tx_sh  <= {1'b0, tx_sh[7:1]};
                tx_idx <= tx_idx + 3'd1;
            end
            case (tx_state)
                START:   TX <= 1'b0;
                DATA:    TX <= tx_sh[0];
                default: TX <= 1'b1;
            endcase
        end
    end

    // RX next-state: samples the synchronised line once per bit at mid-bit.
    always_comb begin
        rx_next    = rx_state;
        rx_push    = 1'b0;
        rx_ovf_set = 1'b0;
        frame_set  = 1'b0;
        case (rx_state)
            IDLE:  rx_next = (rx_prev && !rx_s) ? START : IDLE;
            START: begin
                if (rx_tick) rx_next = rx_s ? IDLE : DATA;
                else         rx_next = START;
            end
            DATA:  rx_next = (rx_tick && rx_idx == 3'd7) ? STOP : DATA;
            STOP: begin
                if (rx_tick) begin
                    rx_next    = IDLE;
                    rx_push    = rx_s & ~rx_full;
                    rx_ovf_set = rx_s & rx_full;
                    frame_set  = ~rx_s;
                end else begin
                    rx_next = STOP;
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    // RX synchroniser, state, half-bit/bit timer and shifter.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= CNT_HALF;
            rx_idx   <= 3'd0;
            rx_sh    <= 8'd0;
        end else begin
            rx_sync  <= {rx_sync[0], RX};
            rx_prev  <= rx_s;
            rx_state <= rx_next;
            if (rx_state == IDLE) rx_cnt <= CNT_HALF;
            else if (rx_tick)     rx_cnt <= CNT_BIT;
            else                  rx_cnt <= rx_cnt - CNT_ONE;
            if (rx_state == START) begin
                rx_idx <= 3'd0;
            end else if (rx_state == DATA && rx_tick) begin
                rx_idx <= rx_idx + 3'd1;
                rx_sh  <= {rx_s, rx_sh[7:1]};
            end
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Testbench for uart_mmio at DIV=10: a line monitor decodes TX into a queue that
// is scored against bytes queued on write; RX frames are driven and scored on read.
module tb_uart_mmio;
    localparam int DIV = 10;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [7:0]  data_in = 8'h00;
    logic [31:0] data_out;
    logic        RX = 1'b1;
    logic        TX;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    logic [7:0] mon_q[$];
    logic       mon_stop_q[$];
    time        mon_t_q[$];

    always #5 CLK = ~CLK;

    uart_mmio #(.CLK_FREQ(1000), .BAUD(100), .FIFO_AW(3)) dut (
        .CLK(CLK), .reset(reset), .en(en), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .RX(RX), .TX(TX)
    );

    // Line monitor: mid-bit sampling of each TX frame.
    always begin
        logic [7:0] b;
        logic       s;
        time        t0;
        @(negedge TX);
        t0 = $time;
        #50;
        if (TX === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                #100;
                b[i] = TX;
            end
            #100;
            s = TX;
            mon_q.push_back(b);
            mon_stop_q.push_back(s);
            mon_t_q.push_back(t0);
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        en = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(negedge CLK);
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge CLK);
        en = 1'b1; wr = 1'b0; addr = a;
        @(negedge CLK);
        en = 1'b0;
        d = data_out;
    endtask

    // Back-to-back DATA writes; only the first n_acc are expected on the line.
    task automatic tx_burst(input logic [7:0] first, input logic [7:0] step, input int n, input int n_acc);
        logic [7:0] v;
        v = first;
        @(negedge CLK);
        en = 1'b1; wr = 1'b1; addr = 4'h0;
        for (int i = 0; i < n; i++) begin
            data_in = v;
            if (i < n_acc) tx_exp_q.push_back(v);
            v = v + step;
            @(negedge CLK);
        end
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        @(negedge CLK);
        RX = 1'b0;
        repeat (DIV) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (DIV) @(negedge CLK);
        end
        RX = stop;
        repeat (DIV) @(negedge CLK);
        RX = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic wait_mon(input int n, input int limit, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (mon_q.size() >= n) break;
            @(negedge CLK);
        end
        ok = (mon_q.size() >= n);
    endtask

    task automatic clear_mon();
        mon_q.delete();
        mon_stop_q.delete();
        mon_t_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (TX !== 1'b1 || data_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: TX=%b data_out=%h, required TX=1 data_out=0", TX, data_out);
        end
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_data_empty: got %h, required 0", d); end
        bus_read(4'h8, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reserved_read: got %h, required 0", d); end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h, required 00000002", d); end
        bus_write(4'hC, 8'h77);
        bus_write(4'h4, 8'h55);
        repeat (5) @(negedge CLK);
        n_checks++;
        if (data_out !== 32'h2 || TX !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_write_ignored: data_out=%h TX=%b, required 00000002 and 1", data_out, TX);
        end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL status_after_reserved_write: got %h, required 00000002", d); end
    endtask

    task automatic test_tx_single();
        logic [7:0]  b;
        logic [31:0] st;
        logic        exp_line;
        int          bad;
        int          first_bad;
        clear_mon();
        b = 8'hA5;
        tx_exp_q.push_back(b);
        bus_write(4'h0, b);
        bad = 0;
        first_bad = -1;
        st = 32'd0;
        for (int k = 0; k < 105; k++) begin
            if (k < 2)       exp_line = 1'b1;
            else if (k < 12) exp_line = 1'b0;
            else if (k < 92) exp_line = b[(k - 12) / 10];
            else             exp_line = 1'b1;
            if (TX !== exp_line) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == 40) begin en = 1'b1; wr = 1'b0; addr = 4'h4; end
            if (k == 41) begin en = 1'b0; st = data_out; end
            @(negedge CLK);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL tx_waveform: %0d wrong samples, first at cycle %0d, required 0", bad, first_bad);
        end
        n_checks++;
        if (st !== 32'h42) begin n_fail++; $display("FAIL tx_busy_status: got %h, required 00000042", st); end
        bus_read(4'h4, st);
        n_checks++;
        if (st !== 32'h2) begin n_fail++; $display("FAIL tx_idle_status: got %h, required 00000002", st); end
        while (tx_exp_q.size() > 0) begin
            b = tx_exp_q.pop_front();
            n_checks++;
            if (mon_q.size() == 0) begin
                n_fail++; $display("FAIL tx_single_byte: no byte decoded, required %h", b);
            end else begin
                logic [7:0] g;
                logic       s;
                g = mon_q.pop_front();
                s = mon_stop_q.pop_front();
                if (g !== b || s !== 1'b1) begin
                    n_fail++; $display("FAIL tx_single_byte: got %h stop %b, required %h stop 1", g, s, b);
                end
            end
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] st;
        logic        ok;
        logic [7:0]  e;
        logic [7:0]  g;
        logic        s;
        clear_mon();
        tx_exp_q.push_back(8'hF0);
        bus_write(4'h0, 8'hF0);
        repeat (3) @(negedge CLK);
        tx_burst(8'h00, 8'h01, 9, 8);
        bus_read(4'h4, st);
        n_checks++;
        if (st !== 32'h61) begin n_fail++; $display("FAIL tx_ovf_first_read: got %h, required 00000061", st); end
        bus_read(4'h4, st);
        n_checks++;
        if (st !== 32'h41) begin n_fail++; $display("FAIL tx_ovf_cleared: got %h, required 00000041", st); end
        wait_mon(9, 1200, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_timeout: decoded %0d bytes, required 9", mon_q.size()); end
        for (int i = 1; i < mon_t_q.size(); i++) begin
            n_checks++;
            if (mon_t_q[i] - mon_t_q[i-1] > 64'd1020) begin
                n_fail++;
                $display("FAIL tx_gap: frame %0d start spacing %0t, required <= 1020", i, mon_t_q[i] - mon_t_q[i-1]);
            end
        end
        while (tx_exp_q.size() > 0) begin
            e = tx_exp_q.pop_front();
            n_checks++;
            if (mon_q.size() == 0) begin
                n_fail++; $display("FAIL tx_ovf_byte: missing, required %h", e);
            end else begin
                g = mon_q.pop_front();
                s = mon_stop_q.pop_front();
                if (g !== e || s !== 1'b1) begin
                    n_fail++; $display("FAIL tx_ovf_byte: got %h stop %b, required %h stop 1", g, s, e);
                end
            end
        end
        repeat (20) @(negedge CLK);
        n_checks++;
        if (mon_q.size() !== 0) begin n_fail++; $display("FAIL tx_ovf_extra: %0d extra bytes, required 0", mon_q.size()); end
        bus_read(4'h4, st);
        n_checks++;
        if (st !== 32'h2) begin n_fail++; $display("FAIL tx_ovf_drained_status: got %h, required 00000002", st); end
    endtask

    task automatic test_rx_byte();
        logic [31:0] d;
        logic [7:0]  e;
        rx_exp_q.push_back(8'h3C);
        rx_frame(8'h3C, 1'b1);
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h6) begin n_fail++; $display("FAIL rx_valid_status: got %h, required 00000006", d); end
        e = rx_exp_q.pop_front();
        bus_read(4'h0, d);
        n_checks++;
        if (d !== {24'd0, e}) begin n_fail++; $display("FAIL rx_data: got %h, required %h", d, {24'd0, e}); end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL rx_empty_status: got %h, required 00000002", d); end
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL rx_empty_read: got %h, required 0", d); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d;
        logic [7:0]  e;
        rx_frame(8'h55, 1'b0);
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h12) begin n_fail++; $display("FAIL frame_err_status: got %h, required 00000012", d); end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL frame_err_cleared: got %h, required 00000002", d); end
        @(negedge CLK);
        RX = 1'b0;
        repeat (4) @(negedge CLK);
        RX = 1'b1;
        repeat (30) @(negedge CLK);
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL glitch_status: got %h, required 00000002", d); end
        for (int i = 0; i < 9; i++) begin
            if (i < 8) rx_exp_q.push_back(8'(8'h10 + i));
            rx_frame(8'(8'h10 + i), 1'b1);
        end
        bus_read(4'h8, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reserved_read_busy: got %h, required 0", d); end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'hE) begin n_fail++; $display("FAIL rx_ovf_status: got %h, required 0000000e", d); end
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            bus_read(4'h0, d);
            n_checks++;
            if (d !== {24'd0, e}) begin n_fail++; $display("FAIL rx_ovf_data: got %h, required %h", d, {24'd0, e}); end
        end
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL rx_ovf_drained: got %h, required 00000002", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic [7:0]  e;
        @(negedge CLK);
        en = 1'b1; wr = 1'b1; addr = 4'h0; data_in = 8'h00;
        RX = 1'b0;
        @(negedge CLK);
        en = 1'b0; wr = 1'b0;
        repeat (43) @(negedge CLK);
        n_checks++;
        if (TX !== 1'b0) begin n_fail++; $display("FAIL mid_frame_line: TX=%b, required 0", TX); end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (TX !== 1'b1) begin n_fail++; $display("FAIL reset_abort_tx: TX=%b, required 1", TX); end
        repeat (3) @(negedge CLK);
        RX = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        bus_read(4'h4, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL reset_abort_status: got %h, required 00000002", d); end
        bus_read(4'h0, d);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_abort_rx_empty: got %h, required 0", d); end
        rx_exp_q.push_back(8'h81);
        rx_frame(8'h81, 1'b1);
        e = rx_exp_q.pop_front();
        bus_read(4'h0, d);
        n_checks++;
        if (d !== {24'd0, e}) begin n_fail++; $display("FAIL rx_after_reset: got %h, required %h", d, {24'd0, e}); end
        repeat (60) @(negedge CLK);
        clear_mon();
    endtask

    task automatic test_pointer_wrap();
        logic [31:0] st;
        logic        ok;
        logic [7:0]  e;
        logic [7:0]  g;
        logic        s;
        clear_mon();
        for (int b = 0; b < 5; b++) begin
            tx_burst(8'(8'h05 + 8'(b * 148)), 8'h25, 4, 4);
            wait_mon(4, 600, ok);
            n_checks++;
            if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout: burst %0d decoded %0d, required 4", b, mon_q.size()); end
            while (tx_exp_q.size() > 0) begin
                e = tx_exp_q.pop_front();
                n_checks++;
                if (mon_q.size() == 0) begin
                    n_fail++; $display("FAIL wrap_byte: missing, required %h", e);
                end else begin
                    g = mon_q.pop_front();
                    s = mon_stop_q.pop_front();
                    if (g !== e || s !== 1'b1) begin
                        n_fail++; $display("FAIL wrap_byte: got %h stop %b, required %h stop 1", g, s, e);
                    end
                end
            end
            mon_t_q.delete();
            repeat (15) @(negedge CLK);
        end
        bus_read(4'h4, st);
        n_checks++;
        if (st !== 32'h2) begin n_fail++; $display("FAIL wrap_status: got %h, required 00000002", st); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_overflow();
        test_rx_byte();
        test_rx_errors();
        test_reset_mid_frame();
        test_pointer_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped 8N1 UART peripheral behind the load/store unit, which decodes the UART address window and drives this block's bus port. Provides TX and RX byte FIFOs, a baud counter, and TX/RX line state machines. Exports TX and consumes RX toward the board pins.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate; DIV = CLK_FREQ/BAUD (integer division), clocks per bit
FIFO_AW, 3, log2 of TX and RX FIFO depth (8 entries each)

Ports:
CLK  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
en  in  1  bus access strobe, one access per asserted cycle
wr  in  1  1 = write, 0 = read; valid with en
addr  in  4  byte offset: 0x0 DATA, 0x4 STATUS; others reserved
data_in  in  8  write data (DATA only)
data_out  out  32  registered read data
RX  in  1  serial input, asynchronous to CLK
TX  out  1  serial output, idle high

Behaviour:
- Reset: TX=1, data_out=0, both FIFOs empty, all sticky flags 0, TX FSM IDLE, RX FSM IDLE, RX synchroniser flops =1.
- Bus read latency 1: data_out updates the cycle after en&~wr and holds until the next read. Writes produce no data_out change.
- DATA write: push data_in into TX FIFO. If TX FIFO is full, drop the byte and set sticky tx_ovf.
- DATA read: data_out = {24'b0, rx head byte}, then pop. If RX FIFO is empty, data_out = 0 with no pop.
- STATUS read: data_out bits: 0 tx_full, 1 tx_empty, 2 rx_valid (not empty), 3 rx_ovf, 4 frame_err, 5 tx_ovf, 6 tx_busy (FSM not IDLE or FIFO not empty); rest 0. The read returns the pre-clear value, then clears bits 3-5 in the same edge. A flag set in that same cycle survives the clear (set wins).
- Reserved addresses: reads return 0; writes are ignored.
- FIFOs: circular, pointers FIFO_AW+1 bits wide, so full/empty are distinguished by the MSB. Wrap-around is seamless. A push and pop on the same cycle is allowed; while full, it still drops the push (no pass-through).
- TX FSM IDLE->START->DATA->STOP->IDLE:
  - IDLE: when the FIFO is non-empty, pop the byte, load it into the shift register, go to START.
  - Each non-IDLE state lasts DIV clocks, counted by a bit counter that reloads at each state entry.
  - START drives 0. DATA drives 8 bits LSB first, with a 3-bit index. STOP drives 1.
  - After STOP, go to IDLE. If the FIFO is non-empty, START begins on the very next cycle.
  - First TX falling edge is 2 cycles after the write is accepted.
- RX path: 2-flop synchroniser on RX; the FSM uses the synchronised value only.
- RX FSM IDLE->START->DATA->STOP->IDLE:
  - IDLE: a falling edge (sync 1 then 0) starts a counter at DIV/2, then go to START.
  - START: at the mid-bit sample, sample=1 is a glitch and returns to IDLE with no flags. Otherwise continue, sampling every DIV clocks.
  - DATA: shift in 8 bits LSB first.
  - STOP: sample. If 1, push the byte; if the RX FIFO is full, drop it and set rx_ovf. If 0, drop the byte and set frame_err. Either way go to IDLE.
- A bus DATA read pop and an RX push on the same cycle are both honoured.
- Asynchronous reset mid-frame aborts both FSMs immediately: TX goes high and partial RX bytes are discarded.

Test Plan:
- Bench parameters: CLK_FREQ=1000, BAUD=100, so DIV=10.
- TX single byte: write 0x0 <- 0xA5 -> TX low at +2 cycles for 10 clocks, bits 1,0,1,0,0,1,0,1 at 10 clocks each, stop high. STATUS bit6=1 during the frame, 0 after it; STATUS reads 0x02 when idle.
- TX overflow: 9 back-to-back writes 0x00..0x08 while the line is busy (first byte already popped) -> 8 queued, 9th dropped. STATUS bit5=1 on first read and 0 on second read. Line emits 0x00..0x07 back-to-back with no idle gap.
- RX byte: drive 8N1 frame for 0x3C -> STATUS bit2=1; DATA read returns 0x0000003C; next STATUS bit2=0; a read from the empty FIFO returns 0.
- RX errors:
  - Frame 0x55 with stop bit 0 -> no push, STATUS=0x12 (tx_empty, frame_err).
  - 4-clock low glitch -> no flags, no data.
  - 9 good frames without reading -> 8 stored, rx_ovf=1, first DATA read returns the first byte.
- Reset mid-frame: assert reset at bit 3 of a TX and an RX frame -> TX=1 immediately. After release, STATUS=0x02 and RX FIFO empty. A following full frame 0x81 is received correctly.
- Pointer wrap: 20 TX bytes written in bursts of 4, waiting for each burst to drain -> all 20 transmitted in order, no ovf flag.
